rsa_pubkey_search: RTL and testbench

Parametrised public-exponent search engine for the RSA key-generation path. Given phi_n and a starting candidate, it walks odd exponents upward until it finds e with gcd(e, phi_n) = 1. It then also returns the private exponent d = e^-1 mod phi_n, normalised to [0, phi_n). It sits between the phi_n computation and the key register file, and adds a programmable start point, a bounded retry count and a failure report.

---
 rtl/rsa_pubkey_search.sv | 148 ++++++++++++++
 tb/tb_rsa_pubkey_search.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_pubkey_search.sv
// rsa_pubkey_search: walks odd exponents upward from e_init to the first e coprime to phi_n.
// Define RSA_KEYSEARCH_DINV_EN to also return d = e^-1 mod phi_n; otherwise d is tied to 0.
module rsa_pubkey_search #(
    parameter int WIDTH = 64,
    parameter int TRY_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_compute,
    input  logic [WIDTH-1:0] phi_n,
    input  logic [WIDTH-1:0] e_init,
    input  logic [TRY_W-1:0] max_tries,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done_compute,
    output logic             fail,
    output logic [TRY_W-1:0] tries
);
    typedef enum logic [2:0] {IDLE, LOAD, DIV, UPDATE, CHECK, NEXT, DONE} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t state, state_nx;
    logic [WIDTH-1:0] cand, r0, r1, rem, dvd, cand_in, rem_nx;
    logic [WIDTH:0] rem_sh, cand_nx;
    logic [CW-1:0] cnt;
    logic q_bit, imm_fail, give_up, last_div;

    assign cand_in  = ((e_init | WIDTH'(1)) < WIDTH'(3)) ? WIDTH'(3) : (e_init | WIDTH'(1));
    assign imm_fail = (cand_in >= phi_n) || (phi_n < WIDTH'(4));
    assign rem_sh   = {rem, dvd[WIDTH-1]};
    assign q_bit    = rem_sh >= {1'b0, r1};
    assign rem_nx   = q_bit ? rem_sh[WIDTH-1:0] - r1 : rem_sh[WIDTH-1:0];
    assign last_div = cnt == CW'(WIDTH - 1);
    // carry out of the candidate increment counts as running past phi_n
    assign cand_nx  = {1'b0, cand} + (WIDTH+1)'(2);
    assign give_up  = ((max_tries != '0) && (tries + TRY_W'(1) == max_tries)) || (cand_nx >= {1'b0, phi_n});
    assign busy         = (state != IDLE) && (state != DONE);
    assign done_compute = state == DONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_compute) state_nx = imm_fail ? DONE : LOAD;
            LOAD:    state_nx = DIV;
            DIV:     if (last_div) state_nx = UPDATE;
            UPDATE:  state_nx = (rem != '0) ? DIV : CHECK;
            CHECK:   state_nx = (r0 == WIDTH'(1)) ? DONE : NEXT;
            NEXT:    state_nx = give_up ? DONE : LOAD;
            DONE:    if (!start_compute) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand  <= '0;
            r0    <= '0;
            r1    <= '0;
            rem   <= '0;
            dvd   <= '0;
            cnt   <= '0;
            e     <= '0;
            tries <= '0;
            fail  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_compute) begin
                    cand  <= cand_in;
                    e     <= '0;
                    tries <= '0;
                    fail  <= imm_fail;
                end
                LOAD: begin
                    r0  <= phi_n;
                    r1  <= cand;
                    dvd <= phi_n;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV: begin
                    rem <= rem_nx;
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                end
                // the old divisor becomes the next dividend
                UPDATE: begin
                    r0  <= r1;
                    r1  <= rem;
                    dvd <= r1;
                    rem <= '0;
                    cnt <= '0;
                end
                CHECK: if (r0 == WIDTH'(1)) e <= cand;
                NEXT: begin
                    tries <= tries + TRY_W'(1);
                    cand  <= cand_nx[WIDTH-1:0];
                    if (give_up) begin
                        fail <= 1'b1;
                        e    <= cand;
                    end
                end
                DONE: if (!start_compute) fail <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef RSA_KEYSEARCH_DINV_EN
    logic signed [WIDTH:0] t0, t1, tacc;
    logic [CW-1:0] sh;

    assign sh = CW'(WIDTH - 1) - cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t0   <= '0;
            t1   <= '0;
            tacc <= '0;
            d    <= '0;
        end else begin
            case (state)
                IDLE: if (start_compute) d <= '0;
                LOAD: begin
                    t0   <= '0;
                    t1   <= (WIDTH+1)'(1);
                    tacc <= '0;
                end
                DIV: if (q_bit) tacc <= tacc - (t1 <<< sh);
                UPDATE: begin
                    t0   <= t1;
                    t1   <= tacc;
                    tacc <= t1;
                end
                CHECK: if (r0 == WIDTH'(1)) d <= t0[WIDTH] ? t0[WIDTH-1:0] + phi_n : t0[WIDTH-1:0];
                default: ;
            endcase
        end
    end
`else
    assign d = '0;
`endif
endmodule

// File: tb/tb_rsa_pubkey_search.sv
// tb_rsa_pubkey_search: table vectors, reset sequences and random runs checked against a
// gcd-based reference model that also predicts the done latency.
module tb_rsa_pubkey_search;
    localparam int W = 64, T = 16, LIMIT = 20000;
`ifdef RSA_KEYSEARCH_DINV_EN
    localparam bit DINV = 1'b1;
`else
    localparam bit DINV = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, start_compute = 1'b0;
    logic [W-1:0] phi_n = '0, e_init = '0;
    logic [T-1:0] max_tries = '0;
    logic [W-1:0] e, d;
    logic busy, done_compute, fail;
    logic [T-1:0] tries;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    rsa_pubkey_search #(.WIDTH(W), .TRY_W(T)) dut (
        .clk(clk), .reset_n(reset_n), .start_compute(start_compute), .phi_n(phi_n),
        .e_init(e_init), .max_tries(max_tries), .e(e), .d(d), .busy(busy),
        .done_compute(done_compute), .fail(fail), .tries(tries)
    );

    typedef struct {
        logic [63:0] phi, ei;
        logic [15:0] mt;
        logic [63:0] xe, xd;
        int xt;
        bit xf;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Search outcome from gcd tests only; cycles = 1 + per candidate (2 + steps*(W+1)) + 1 per rejection
    function automatic void model(input logic [63:0] phi, input logic [63:0] ei, input logic [15:0] mt,
                                  output logic [63:0] xe, output int xt, output bit xf, output int cyc);
        logic [63:0] c, a, b, r;
        logic [64:0] c2;
        int k;
        bit fin;
        c = ei | 64'd1;
        if (c < 64'd3) c = 64'd3;
        xe = '0; xt = 0; xf = 1'b0; cyc = 1; fin = 1'b0;
        if (c >= phi || phi < 64'd4) begin
            xf = 1'b1;
            fin = 1'b1;
        end
        while (!fin) begin
            a = phi; b = c; k = 0;
            while (b != 0) begin
                r = a % b; a = b; b = r; k++;
            end
            cyc += 2 + k * (W + 1);
            if (a == 64'd1) begin
                xe = c;
                fin = 1'b1;
            end else begin
                cyc++; xt++;
                c2 = {1'b0, c} + 65'd2;
                if ((mt != 0 && xt == int'(mt)) || c2 >= {1'b0, phi}) begin
                    xf = 1'b1; xe = c; fin = 1'b1;
                end else c = c2[63:0];
            end
        end
    endfunction

    task automatic reset_pulse();
        start_compute = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // use_xd: compare d with a known constant, otherwise check e*d == 1 mod phi
    task automatic apply(input string nm, input logic [63:0] phi, input logic [63:0] ei, input logic [15:0] mt,
                         input logic [63:0] xe, input int xt, input bit xf, input bit use_xd, input logic [63:0] xd);
        logic [63:0] me;
        logic [127:0] prod;
        int mt_t, cyc, lat;
        bit mf;
        model(phi, ei, mt, me, mt_t, mf, cyc);
        phi_n = phi; e_init = ei; max_tries = mt; start_compute = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk({nm, ".busy_rise"}, 64'(busy), 64'(cyc > 1));
        end while (!done_compute && lat < LIMIT);
        if (!done_compute) begin
            checks++; errors++;
            $display("FAIL %s.timeout: no done after %0d cycles", nm, lat);
            reset_pulse();
            return;
        end
        chk({nm, ".latency"}, 64'(lat), 64'(cyc));
        chk({nm, ".e"}, e, xe);
        chk({nm, ".tries"}, 64'(tries), 64'(xt));
        chk({nm, ".fail"}, 64'(fail), 64'(xf));
        chk({nm, ".busy_fall"}, 64'(busy), 64'd0);
        if (use_xd || xf || !DINV) chk({nm, ".d"}, d, (DINV && !xf) ? xd : 64'd0);
        else begin
            prod = 128'(xe) * 128'(d);
            checks++;
            if (!(d < phi && prod % 128'(phi) == 128'd1)) begin
                errors++;
                $display("FAIL %s.d_inverse: got d=%0d for e=%0d phi=%0d", nm, d, xe, phi);
            end
        end
        @(posedge clk); #1;
        chk({nm, ".done_held"}, 64'(done_compute), 64'd1);
        start_compute = 1'b0;
        @(posedge clk); #1;
        chk({nm, ".done_clear"}, 64'(done_compute), 64'd0);
        chk({nm, ".fail_clear"}, 64'(fail), 64'd0);
        chk({nm, ".e_hold"}, e, xe);
    endtask

    initial begin
        logic [63:0] rphi, rei, me;
        logic [15:0] rmt;
        int mt_t, cyc, lat;
        bit mf;
        tbl[0]  = '{64'd3120, 64'd3,     16'd0, 64'd7,  64'd1783, 2, 1'b0};
        tbl[1]  = '{64'd60,   64'd0,     16'd0, 64'd7,  64'd43,   2, 1'b0};
        tbl[2]  = '{64'd3120, 64'd65537, 16'd0, 64'd0,  64'd0,    0, 1'b1};
        tbl[3]  = '{64'd3120, 64'd3,     16'd1, 64'd3,  64'd0,    1, 1'b1};
        tbl[4]  = '{64'd3120, 64'd3,     16'd2, 64'd5,  64'd0,    2, 1'b1};
        tbl[5]  = '{64'd3120, 64'd2,     16'd3, 64'd7,  64'd1783, 2, 1'b0};
        tbl[6]  = '{64'd3,    64'd0,     16'd0, 64'd0,  64'd0,    0, 1'b1};
        tbl[7]  = '{64'd10,   64'd9,     16'd0, 64'd9,  64'd9,    0, 1'b0};
        tbl[8]  = '{64'd12,   64'd3,     16'd0, 64'd5,  64'd5,    1, 1'b0};
        tbl[9]  = '{64'd12,   64'd8,     16'd0, 64'd11, 64'd11,   1, 1'b0};
        tbl[10] = '{64'd10,   64'd5,     16'd0, 64'd7,  64'd3,    1, 1'b0};
        tbl[11] = '{64'd8,    64'd6,     16'd0, 64'd7,  64'd7,    0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.e", e, 64'd0);
        chk("reset.d", d, 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done_compute), 64'd0);
        chk("reset.fail", 64'(fail), 64'd0);
        chk("reset.tries", 64'(tries), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), tbl[i].phi, tbl[i].ei, tbl[i].mt,
                  tbl[i].xe, tbl[i].xt, tbl[i].xf, 1'b1, tbl[i].xd);

        // reset while a completed result is being held
        phi_n = 64'd3120; e_init = 64'd3; max_tries = '0; start_compute = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done_compute && lat < LIMIT);
        chk("hold.e_before_reset", e, 64'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("hold_reset.e", e, 64'd0);
        chk("hold_reset.d", d, 64'd0);
        chk("hold_reset.done", 64'(done_compute), 64'd0);
        chk("hold_reset.tries", 64'(tries), 64'd0);
        start_compute = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // reset in the middle of the first divide, then reissue
        start_compute = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("middiv.busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("middiv_reset.busy", 64'(busy), 64'd0);
        chk("middiv_reset.done", 64'(done_compute), 64'd0);
        chk("middiv_reset.e", e, 64'd0);
        start_compute = 1'b0;
        @(posedge clk); #1;
        chk("middiv_reset.held_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        apply("rerun", 64'd3120, 64'd3, 16'd0, 64'd7, 2, 1'b0, 1'b1, 64'd1783);

        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                rphi = 64'($urandom_range(4000, 2));
                rei  = 64'($urandom_range(4100, 0));
                rmt  = 16'($urandom_range(3, 0));
            end else begin
                rphi = {$urandom, $urandom};
                rei  = 64'($urandom_range(1000, 0));
                rmt  = 16'($urandom_range(3, 1));
            end
            model(rphi, rei, rmt, me, mt_t, mf, cyc);
            apply($sformatf("rnd%0d", i), rphi, rei, rmt, me, mt_t, mf, 1'b0, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
